// File: rtl/quiz_round_ctrl_pkg.sv
// Shared types and widths for the quiz round sequencer.
package quiz_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_Q    = 3'd1,
    WAIT_Q   = 3'd2,
    ANSWER   = 3'd3,
    FEEDBACK = 3'd4,
    DONE     = 3'd5
  } quiz_state_t;

  localparam int Q_IDX_W    = 4;
  localparam int TL_W       = 4;
  localparam int STREAK_LEN = 3;
endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Bundle between the round sequencer (slave) and the game environment (master).
// start, q_ready, ans_valid and q_req are single-cycle qualifiers sampled on the rising clock
// edge. There is no back-pressure. q_ready may be held as a level; it is only honoured in WAIT_Q.
interface quiz_round_ctrl_if
  import quiz_pkg::*;
#(
  parameter int SCORE_W = 5
) ();
  logic               start;
  logic               q_req;
  logic               q_ready;
  logic               ans_valid;
  logic               ans_correct;
  logic [Q_IDX_W-1:0] q_idx;
  logic [TL_W-1:0]    time_left;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               fb_active;
  logic               fb_correct;
  logic               round_done;
  logic               done;
  quiz_state_t        state;

  modport master (
    output start, q_ready, ans_valid, ans_correct,
    input  q_req, q_idx, time_left, score, busy, fb_active, fb_correct,
           round_done, done, state
  );

  modport slave (
    input  start, q_ready, ans_valid, ans_correct,
    output q_req, q_idx, time_left, score, busy, fb_active, fb_correct,
           round_done, done, state
  );
endinterface

// File: rtl/quiz_round_ctrl_tick_div.sv
// Divide-by-DIV prescaler: counts while en, emits a one-cycle tick on the wrap to zero.
module quiz_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: question request, timed answer window, scoring and feedback hold.
// Optional macro STREAK_BONUS_EN: every third consecutive correct answer scores 2.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int NUM_Q         = 10,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int Q_TIME_S      = 10,
  parameter int FB_CYCLES     = 25000000,
  parameter int SCORE_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  quiz_round_ctrl_if.slave   bus
);
  localparam int                 FB_W      = (FB_CYCLES > 1) ? $clog2(FB_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  quiz_state_t        state, state_next;
  logic [Q_IDX_W-1:0] q_idx;
  logic [TL_W-1:0]    time_left;
  logic [SCORE_W-1:0] score, score_sat;
  logic [SCORE_W:0]   score_sum;
  logic [1:0]         add;
  logic [FB_W-1:0]    fb_cnt;
  logic               fb_correct, round_done;
  logic               sec_tick, fb_last, last_q, expire;

`ifdef STREAK_BONUS_EN
  logic [1:0] streak;
  logic       bonus;
  assign bonus = bus.ans_correct && (streak == 2'(STREAK_LEN - 1));
`endif

  quiz_tick_div #(.DIV(TICKS_PER_SEC)) u_sec_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ANSWER),
    .clr  ((state == WAIT_Q) && bus.q_ready),
    .tick (sec_tick)
  );

  assign fb_last = (fb_cnt == FB_W'(FB_CYCLES - 1));
  assign last_q  = (q_idx == Q_IDX_W'(NUM_Q - 1));
  assign expire  = sec_tick && (time_left == TL_W'(1));

  always_comb begin
    add = {1'b0, bus.ans_correct};
`ifdef STREAK_BONUS_EN
    if (bonus) add = 2'd2;
`endif
    score_sum = {1'b0, score} + (SCORE_W + 1)'(add);
    score_sat = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (bus.start) state_next = REQ_Q;
      REQ_Q:      state_next = WAIT_Q;
      WAIT_Q:     if (bus.q_ready) state_next = ANSWER;
      ANSWER:     if (bus.ans_valid || expire) state_next = FEEDBACK;
      FEEDBACK:   if (fb_last) state_next = last_q ? DONE : REQ_Q;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q_idx      <= '0;
      time_left  <= '0;
      score      <= '0;
      fb_correct <= 1'b0;
      fb_cnt     <= '0;
      round_done <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak     <= '0;
`endif
    end else begin
      state      <= state_next;
      round_done <= (state == FEEDBACK) && fb_last && last_q;
      fb_cnt     <= ((state == FEEDBACK) && !fb_last) ? fb_cnt + FB_W'(1) : '0;
      unique case (state)
        IDLE, DONE: if (bus.start) begin
          score <= '0;
          q_idx <= '0;
`ifdef STREAK_BONUS_EN
          streak <= '0;
`endif
        end
        WAIT_Q: if (bus.q_ready) time_left <= TL_W'(Q_TIME_S);
        // An answer landing on the expiring tick still counts; time_left then stays put.
        ANSWER: if (bus.ans_valid) begin
          fb_correct <= bus.ans_correct;
          score      <= score_sat;
`ifdef STREAK_BONUS_EN
          streak     <= (!bus.ans_correct || bonus) ? 2'd0 : streak + 2'd1;
`endif
        end else if (sec_tick) begin
          time_left <= time_left - TL_W'(1);
          if (expire) begin
            fb_correct <= 1'b0;
`ifdef STREAK_BONUS_EN
            streak     <= '0;
`endif
          end
        end
        FEEDBACK: if (fb_last && !last_q) q_idx <= q_idx + Q_IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.q_req      = (state == REQ_Q);
  assign bus.busy       = (state != IDLE) && (state != DONE);
  assign bus.fb_active  = (state == FEEDBACK);
  assign bus.done       = (state == DONE);
  assign bus.round_done = round_done;
  assign bus.fb_correct = fb_correct;
  assign bus.q_idx      = q_idx;
  assign bus.time_left  = time_left;
  assign bus.score      = score;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: idle vector table, directed rounds, random rounds vs a reference model.
module tb_quiz_round_ctrl;
  import quiz_pkg::*;

  localparam int NUM_Q = 3;
  localparam int TPS   = 4;
  localparam int QT    = 3;
  localparam int FB    = 2;
  localparam int SW    = 5;
  localparam int WIN   = QT * TPS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quiz_round_ctrl_if #(.SCORE_W(SW)) bus ();

  quiz_round_ctrl #(
    .NUM_Q(NUM_Q), .TICKS_PER_SEC(TPS), .Q_TIME_S(QT), .FB_CYCLES(FB), .SCORE_W(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: score and streak follow the game rules directly.
  int             m_score;
  int             m_streak;
  logic [SW+4:0]  exp_q[$];

  typedef struct {
    logic        start, q_ready, ans_valid, ans_correct;
    quiz_state_t st;
    logic        q_req, busy;
    logic [3:0]  tl;
    logic [SW-1:0] sc;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start();
    m_score  = 0;
    m_streak = 0;
  endtask

  task automatic model_result(input bit answered, input bit correct, input int d);
    int add, tl;
    add = 0;
    if (answered && correct) begin
      add = 1;
`ifdef STREAK_BONUS_EN
      m_streak++;
      if (m_streak == STREAK_LEN) begin
        add      = 2;
        m_streak = 0;
      end
`endif
    end else begin
      m_streak = 0;
    end
    m_score = (m_score + add > (1 << SW) - 1) ? (1 << SW) - 1 : m_score + add;
    tl      = answered ? QT - d / TPS : 0;
    exp_q.push_back({1'(answered && correct), 4'(tl), SW'(m_score)});
  endtask

  task automatic start_round();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    model_start();
    check("start_clears_score", bus.score, 0);
    check("start_clears_done", bus.done, 0);
  endtask

  // Entered at the negedge of the REQ_Q cycle; leaves after feedback (REQ_Q or DONE).
  task automatic run_question(input int qi, input int r, input int d, input bit correct,
                              input bit noise);
    bit            answered;
    logic [SW+4:0] e;
    check("q_req", bus.q_req, 1);
    check("q_idx", bus.q_idx, qi);
    check("busy", bus.busy, 1);
    @(negedge clk);
    check("wait_state", bus.state, WAIT_Q);
    check("q_req_one_cycle", bus.q_req, 0);
    repeat (r) @(negedge clk);
    bus.q_ready     = 1'b1;
    bus.ans_valid   = noise;
    bus.ans_correct = 1'b1;
    bus.start       = noise;
    @(negedge clk);
    bus.q_ready   = 1'b0;
    bus.ans_valid = 1'b0;
    bus.start     = 1'b0;
    answered = (d < WIN);
    for (int c = 0; c < WIN; c++) begin
      check("ans_state", bus.state, ANSWER);
      check("time_left", bus.time_left, QT - c / TPS);
      if (answered && c == d) begin
        bus.ans_valid   = 1'b1;
        bus.ans_correct = correct;
        @(negedge clk);
        bus.ans_valid   = 1'b0;
        bus.ans_correct = 1'b0;
        break;
      end
      @(negedge clk);
    end
    model_result(answered, correct, d);
    e = exp_q.pop_front();
    check("fb_active", bus.fb_active, 1);
    check("fb_correct", bus.fb_correct, e[SW+4]);
    check("fb_time_left", bus.time_left, e[SW+3:SW]);
    check("score", bus.score, e[SW-1:0]);
    @(negedge clk);
    check("fb_hold", bus.fb_active, 1);
    check("fb_tl_frozen", bus.time_left, e[SW+3:SW]);
    @(negedge clk);
    check("fb_end", bus.fb_active, 0);
    if (qi == NUM_Q - 1) begin
      check("round_done", bus.round_done, 1);
      check("done", bus.done, 1);
      check("done_busy", bus.busy, 0);
      check("done_q_idx", bus.q_idx, NUM_Q - 1);
      check("done_score", bus.score, m_score);
      @(negedge clk);
      check("round_done_pulse", bus.round_done, 0);
      check("done_level", bus.done, 1);
      check("done_score_held", bus.score, m_score);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.q_ready = 1'b0; bus.ans_valid = 1'b0; bus.ans_correct = 1'b0;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b0, 1'b0, 4'd0, '0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, IDLE,   1'b0, 1'b0, 4'd0, '0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, IDLE,   1'b0, 1'b0, 4'd0, '0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, REQ_Q,  1'b1, 1'b1, 4'd0, '0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, WAIT_Q, 1'b0, 1'b1, 4'd0, '0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, WAIT_Q, 1'b0, 1'b1, 4'd0, '0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, ANSWER, 1'b0, 1'b1, 4'(QT), '0};

    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", bus.state, IDLE);
    check("rst_q_req", bus.q_req, 0);
    check("rst_score", bus.score, 0);
    check("rst_q_idx", bus.q_idx, 0);
    check("rst_time_left", bus.time_left, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fb_active", bus.fb_active, 0);
    check("rst_fb_correct", bus.fb_correct, 0);
    check("rst_round_done", bus.round_done, 0);
    check("rst_done", bus.done, 0);

    for (int i = 0; i < 7; i++) begin
      bus.start = vecs[i].start; bus.q_ready = vecs[i].q_ready;
      bus.ans_valid = vecs[i].ans_valid; bus.ans_correct = vecs[i].ans_correct;
      @(negedge clk);
      bus.start = 1'b0; bus.q_ready = 1'b0; bus.ans_valid = 1'b0; bus.ans_correct = 1'b0;
      check("vec_state", bus.state, vecs[i].st);
      check("vec_q_req", bus.q_req, vecs[i].q_req);
      check("vec_busy", bus.busy, vecs[i].busy);
      check("vec_time_left", bus.time_left, vecs[i].tl);
      check("vec_score", bus.score, vecs[i].sc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("vec_rst_state", bus.state, IDLE);
    check("vec_rst_time_left", bus.time_left, 0);

    // Full correct round with fixed timing
    start_round();
    for (int q = 0; q < NUM_Q; q++) run_question(q, 1, 4, 1'b1, 1'b0);
`ifdef STREAK_BONUS_EN
    check("full_round_score", bus.score, 4);
`else
    check("full_round_score", bus.score, 3);
`endif

    // Timeout, answer on the expiring tick, wrong answer; restart from DONE
    start_round();
    run_question(0, 0, WIN + 1, 1'b1, 1'b1);
    run_question(1, 2, WIN - 1, 1'b1, 1'b0);
    run_question(2, 0, 0, 1'b0, 1'b1);
    check("mixed_round_score", bus.score, 1);

    // Reset in the middle of question 1
    start_round();
    run_question(0, 1, 2, 1'b1, 1'b0);
    check("mr_q_req", bus.q_req, 1);
    @(negedge clk);
    bus.q_ready = 1'b1;
    @(negedge clk);
    bus.q_ready = 1'b0;
    check("mr_answer", bus.state, ANSWER);
    check("mr_q_idx", bus.q_idx, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_state", bus.state, IDLE);
    check("mr_score", bus.score, 0);
    check("mr_time_left", bus.time_left, 0);
    check("mr_q_idx0", bus.q_idx, 0);
    check("mr_busy", bus.busy, 0);
    start_round();
    for (int q = 0; q < NUM_Q; q++) run_question(q, 0, 1, 1'b1, 1'b0);

`ifdef STREAK_BONUS_EN
    start_round();
    for (int q = 0; q < NUM_Q; q++) run_question(q, 0, 2, 1'b1, 1'b0);
    check("streak_bonus_score", bus.score, 4);
    start_round();
    run_question(0, 0, 2, 1'b1, 1'b0);
    run_question(1, 0, 2, 1'b0, 1'b0);
    run_question(2, 0, 2, 1'b1, 1'b0);
    check("streak_broken_score", bus.score, 2);
`endif

    // Random rounds
    for (int rnd = 0; rnd < 6; rnd++) begin
      start_round();
      for (int q = 0; q < NUM_Q; q++)
        run_question(q, $urandom_range(0, 3), $urandom_range(0, WIN + 1),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Round sequencer for the math game.
- Runs a round of NUM_Q questions: requests each question from the problem generator, then times the player's answer with a seconds countdown.
- Scores answers, holds a feedback window after each one, and signals round completion.
- Sits between the player-input debouncer/compare logic and the display/score driver.
- Owns a 1-second tick prescaler, a generalised divide-by-N counter.

Parameters:
NUM_Q, 10, questions per round (1..15)
TICKS_PER_SEC, 50000000, clk cycles per second tick (small values for simulation)
Q_TIME_S, 10, seconds allowed per question (1..15)
FB_CYCLES, 25000000, clk cycles the feedback window is held (>=1)
SCORE_W, 5, score register width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a round
q_req  out  1  one-cycle pulse requesting the next question
q_ready  in  1  generator has presented the question (pulse or level; sampled only in WAIT_Q)
ans_valid  in  1  one-cycle pulse: player submitted an answer
ans_correct  in  1  qualifies ans_valid
q_idx  out  4  current question index, 0-based
time_left  out  4  seconds remaining for the current question
score  out  SCORE_W  correct-answer count
busy  out  1  high in any state except IDLE and DONE
fb_active  out  1  high during FEEDBACK
fb_correct  out  1  result of the last question (1 = correct, 0 = wrong or timeout); valid while fb_active
round_done  out  1  one-cycle pulse on entry to DONE
done  out  1  level; high in DONE

Behaviour:
- Reset: clk edge with rst=1 → state IDLE.
  - All outputs 0, including score, q_idx and time_left.
  - Prescaler and feedback counter are cleared.
  - Reset overrides everything, including mid-round.
- States: IDLE, REQ_Q, WAIT_Q, ANSWER, FEEDBACK, DONE.
- IDLE/DONE + start → REQ_Q.
  - Clear score and q_idx.
  - Clear done.
  - start in any other state is ignored.
- REQ_Q: q_req=1 for exactly one cycle → WAIT_Q.
- WAIT_Q: wait indefinitely. On q_ready=1:
  - time_left ← Q_TIME_S.
  - Clear the prescaler.
  - → ANSWER.
- ANSWER:
  - sec_tick is high one cycle every TICKS_PER_SEC cycles; the first tick comes TICKS_PER_SEC cycles after entry.
  - On each sec_tick, time_left decrements.
  - ans_valid=1:
    - fb_correct ← ans_correct.
    - score += ans_correct.
    - → FEEDBACK.
  - sec_tick with time_left==1 and no ans_valid (timeout):
    - time_left ← 0.
    - fb_correct ← 0.
    - → FEEDBACK.
  - ans_valid and the expiring tick in the same cycle: the answer wins and is scored normally.
- FEEDBACK:
  - fb_active=1 for exactly FB_CYCLES cycles.
  - Then, if q_idx==NUM_Q-1 → DONE with round_done pulsed once.
  - Otherwise q_idx+1 → REQ_Q.
  - time_left is frozen during FEEDBACK.
- DONE: done=1; score and q_idx are held.
- ans_valid outside ANSWER is ignored (no score change).
- Latency:
  - start → q_req: 1 cycle.
  - ans_valid → fb_active: 1 cycle.
- Score saturates at 2^SCORE_W-1 and never wraps.
- Prescaler:
  - Wraps from TICKS_PER_SEC-1 to 0, emitting the tick on the wrap.
  - Counts only in ANSWER.
  - Width is $clog2(TICKS_PER_SEC).

Optional Feature:
Macro STREAK_BONUS_EN.
- Defined:
  - A 2-bit streak counter increments on each correct answer.
  - Every third consecutive correct answer adds 2 to score instead of 1, with saturation; the streak then returns to 0.
  - A wrong answer or timeout clears the streak.
  - The streak clears on start and on rst.
- Undefined: no streak logic; every correct answer adds exactly 1.

Decomposition:
- Package quiz_pkg holds:
  - state enum quiz_state_t (IDLE, REQ_Q, WAIT_Q, ANSWER, FEEDBACK, DONE);
  - localparam Q_IDX_W=4 and TL_W=4;
  - streak threshold STREAK_LEN=3.
- Sub-module quiz_tick_div:
  - Ports: clk, rst, en, clr, tick; parameter DIV.
  - Free-running divide-by-DIV with a one-cycle tick.
  - Instantiated once for sec_tick.

Test Plan:
All scenarios use NUM_Q=3, TICKS_PER_SEC=4, Q_TIME_S=3, FB_CYCLES=2.
- Reset/idle: rst high 3 cycles, then low; ans_valid and q_ready pulses → no state change; all outputs 0; busy=0.
- Full correct round: start; q_ready 2 cycles after each q_req; ans_valid+ans_correct 5 cycles after each q_ready → 3 q_req pulses; score=3; round_done one pulse; done=1; q_idx=2.
- Timeout: q_ready, then no answer → time_left goes 3,2,1,0 at 4-cycle intervals; fb_active for 2 cycles with fb_correct=0; score unchanged; next q_req follows.
- Simultaneous: ans_valid+ans_correct in the same cycle as the final tick → fb_correct=1; score+1.
- Mid-round reset: rst during ANSWER of q_idx=1 → next cycle state IDLE; score=0; time_left=0; a subsequent start begins at q_idx=0.
- STREAK_BONUS_EN build: 3 consecutive correct answers → score=4; repeat with a wrong answer second → score=2.
